// File: rtl/psum_pkg.sv
// Shared types and helpers for the psum accumulation bank.
package psum_pkg;

  typedef enum logic {
    CLEAR  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic logic signed [63:0] sat_max(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/psum_acc_bank_if.sv
// Psum input stream, result stream, and control/status bundle of the accumulation bank.
interface psum_acc_bank_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int aw      = $clog2(depth)
) ();
  logic                   clr;
  logic                   relu_en;
  logic                   sat_en;
  logic                   in_valid;
  logic                   in_ready;
  logic [psum_bw*col-1:0] in_data;
  logic [aw-1:0]          in_addr;
  logic                   in_first;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [psum_bw*col-1:0] out_data;
  logic [aw-1:0]          out_addr;
  logic                   busy;
  logic [aw:0]            emit_cnt;

  modport master (
    output clr, relu_en, sat_en, in_valid, in_data, in_addr, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_addr, busy, emit_cnt
  );

  modport slave (
    input  clr, relu_en, sat_en, in_valid, in_data, in_addr, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_addr, busy, emit_cnt
  );
endinterface

// File: rtl/psum_add_sat.sv
// One channel of the accumulate path: overwrite, wrapping add, or saturating add.
module psum_add_sat
  import psum_pkg::*;
#(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] acc_i,
  input  logic [psum_bw-1:0] data_i,
  input  logic               first_i,
  input  logic               sat_en_i,
  output logic [psum_bw-1:0] sum_o
);
  localparam logic signed [63:0] MAX64 = sat_max(psum_bw);
  localparam logic signed [63:0] MIN64 = sat_min(psum_bw);
  localparam logic [psum_bw-1:0] MAXV  = MAX64[psum_bw-1:0];
  localparam logic [psum_bw-1:0] MINV  = MIN64[psum_bw-1:0];

  logic [psum_bw:0] sum_ext;
  logic             ovf;

  // One guard bit: overflow shows up as guard and sign bits disagreeing.
  always_comb begin
    sum_ext = {acc_i[psum_bw-1], acc_i} + {data_i[psum_bw-1], data_i};
    ovf     = sum_ext[psum_bw] ^ sum_ext[psum_bw-1];
    if (first_i)
      sum_o = data_i;
    else if (sat_en_i && ovf)
      sum_o = sum_ext[psum_bw] ? MINV : MAXV;
    else
      sum_o = sum_ext[psum_bw-1:0];
  end
endmodule

// File: rtl/psum_acc_bank.sv
// Addressed psum accumulation buffer with clear sequencer and backpressured result register.
//   state  | meaning
//   CLEAR  | zeroing entry clr_ptr each cycle, inputs blocked
//   ACTIVE | accepting psum vectors, emitting results on last pass
module psum_acc_bank
  import psum_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int aw      = $clog2(depth)
) (
  input  logic            clk,
  input  logic            reset,
  psum_acc_bank_if.slave  acc_if
);
  localparam int W = col * psum_bw;
  localparam logic [aw-1:0] LAST_PTR  = aw'(depth - 1);
  localparam logic [aw:0]   CNT_LIMIT = (aw + 1)'(depth);

  state_e          state_q, state_d;
  logic [aw-1:0]   clr_ptr_q, clr_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [aw-1:0]   out_addr_q, out_addr_d;
  logic [aw:0]     emit_cnt_q, emit_cnt_d;
  logic [W-1:0]    buf_q [depth];
  logic [W-1:0]    rd_row, new_row, relu_row;
  logic            in_ready, accept;

  assign rd_row   = buf_q[acc_if.in_addr];
  assign in_ready = (state_q == ACTIVE) && !acc_if.clr && (!out_valid_q || acc_if.out_ready);
  assign accept   = acc_if.in_valid && in_ready;

  for (genvar i = 0; i < col; i++) begin : g_ch
    psum_add_sat #(.psum_bw(psum_bw)) u_add (
      .acc_i    (rd_row[i*psum_bw +: psum_bw]),
      .data_i   (acc_if.in_data[i*psum_bw +: psum_bw]),
      .first_i  (acc_if.in_first),
      .sat_en_i (acc_if.sat_en),
      .sum_o    (new_row[i*psum_bw +: psum_bw])
    );
    // ReLU only shapes the emitted copy; the stored entry keeps its sign.
    assign relu_row[i*psum_bw +: psum_bw] =
      (acc_if.relu_en && new_row[i*psum_bw + psum_bw - 1]) ? '0 : new_row[i*psum_bw +: psum_bw];
  end

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    emit_cnt_d  = emit_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    case (state_q)
      CLEAR: begin
        if (acc_if.clr) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == LAST_PTR) begin
          state_d   = ACTIVE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + aw'(1);
        end
      end
      ACTIVE: begin
        if (acc_if.clr) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (acc_if.clr)
      emit_cnt_d = '0;
    if (accept && acc_if.in_last) begin
      out_valid_d = 1'b1;
      out_data_d  = relu_row;
      out_addr_d  = acc_if.in_addr;
      if (emit_cnt_q != CNT_LIMIT)
        emit_cnt_d = emit_cnt_q + (aw + 1)'(1);
    end else if (out_valid_q && acc_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      emit_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      emit_cnt_q  <= emit_cnt_d;
    end
  end

  // Buffer contents are owned by the CLEAR sequence, so no reset here.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      buf_q[clr_ptr_q] <= '0;
    else if (accept)
      buf_q[acc_if.in_addr] <= new_row;
  end

  assign acc_if.in_ready  = in_ready;
  assign acc_if.out_valid = out_valid_q;
  assign acc_if.out_data  = out_data_q;
  assign acc_if.out_addr  = out_addr_q;
  assign acc_if.busy      = (state_q == CLEAR);
  assign acc_if.emit_cnt  = emit_cnt_q;
endmodule
